// File: rtl/hls_pkg.sv
// hls_pkg: shared definitions for the hls_test1_param datapath.
//   state_t    - FSM state encoding (WAIT, LOAD, MUL, COMMIT, FINAL)
//   cnt_width  - width of the multiply wait counter for a given latency
package hls_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_LOAD   = 3'd1,
        S_MUL    = 3'd2,
        S_COMMIT = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    // One extra bit keeps MUL_LATENCY-1 representable for every latency >= 1.
    function automatic int cnt_width(input int lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/hls_mul_pipe.sv
// hls_mul_pipe: MUL_LATENCY-stage registered multiplier.
//   Clk, Rst  - clock, synchronous active-high reset (clears every stage)
//   in_vld    - launch strobe; a*b is captured into stage 0 on this edge
//   a, b      - DATAWIDTH operands, signed when SIGNED != 0
//   p         - full 2*DATAWIDTH product from the last stage
//   p_vld     - high the cycle p carries the launched product
module hls_mul_pipe #(
    parameter int DATAWIDTH   = 16,
    parameter int SIGNED      = 0,
    parameter int MUL_LATENCY = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   in_vld,
    input  logic [DATAWIDTH-1:0]   a,
    input  logic [DATAWIDTH-1:0]   b,
    output logic [2*DATAWIDTH-1:0] p,
    output logic                   p_vld
);
    localparam int PW = 2 * DATAWIDTH;

    logic [PW-1:0]                    prod_c;
    logic [MUL_LATENCY-1:0]           vld_pipe;
    logic [MUL_LATENCY-1:0][PW-1:0]   stg;

    // Operands are widened to the product width first so the signed case
    // sign-extends and the multiply is done at full precision.
    generate
        if (SIGNED != 0) begin : g_signed
            assign prod_c = PW'($signed(a)) * PW'($signed(b));
        end else begin : g_unsigned
            assign prod_c = PW'(a) * PW'(b);
        end
    endgenerate

    // Each stage only advances on a valid token, so the result parks in
    // the last stage until the next launch.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_pipe <= '0;
            stg      <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            if (in_vld)
                stg[0] <= prod_c;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1])
                    stg[i] <= stg[i-1];
            end
        end
    end

    assign p     = stg[MUL_LATENCY-1];
    assign p_vld = vld_pipe[MUL_LATENCY-1];

endmodule

// File: rtl/hls_test1_param.sv
// hls_test1_param: FSM-scheduled datapath
//   z = low Z_WIDTH bits of max(a+b, a+c)   (tie selects a+c)
//   x = a*c - (a+b) mod 2^DATAWIDTH
//   Clk, Rst  - clock, synchronous active-high reset
//   Start     - request, sampled only in WAIT; a, b, c captured on that edge
//   Busy      - high in every state except WAIT
//   Done      - one-cycle pulse while z/x carry the new result
//   z, x      - result registers, held until the next COMMIT
module hls_test1_param
    import hls_pkg::*;
#(
    parameter int DATAWIDTH   = 16,
    parameter int Z_WIDTH     = 8,
    parameter int SIGNED      = 0,
    parameter int MUL_LATENCY = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 Busy,
    output logic                 Done,
    output logic [Z_WIDTH-1:0]   z,
    output logic [DATAWIDTH-1:0] x
);
    localparam int CNT_W = cnt_width(MUL_LATENCY);
    localparam int PW    = 2 * DATAWIDTH;

    state_t               state;
    logic [DATAWIDTH-1:0] a_r, b_r, c_r;
    logic [DATAWIDTH-1:0] ab_r, ac_r;
    logic [PW-1:0]        prod_r;
    logic [CNT_W-1:0]     cnt;

    logic                 mul_go;
    logic [PW-1:0]        mul_p;
    logic                 mul_vld;
    logic                 ab_gt;

    // The multiply is launched from the captured operands during LOAD;
    // they stay put for the whole operation, so the pipe sees stable inputs.
    assign mul_go = (state == S_LOAD);

    hls_mul_pipe #(
        .DATAWIDTH   (DATAWIDTH),
        .SIGNED      (SIGNED),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul (
        .Clk    (Clk),
        .Rst    (Rst),
        .in_vld (mul_go),
        .a      (a_r),
        .b      (c_r),
        .p      (mul_p),
        .p_vld  (mul_vld)
    );

    generate
        if (SIGNED != 0) begin : g_cmp_s
            assign ab_gt = $signed(ab_r) > $signed(ac_r);
        end else begin : g_cmp_u
            assign ab_gt = ab_r > ac_r;
        end
    endgenerate

    // Product lands at the last MUL edge at the latest, ahead of COMMIT.
    always_ff @(posedge Clk) begin
        if (Rst)
            prod_r <= '0;
        else if (mul_vld)
            prod_r <= mul_p;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_WAIT;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
            ab_r  <= '0;
            ac_r  <= '0;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            z     <= '0;
            x     <= '0;
        end else begin
            unique case (state)
                S_WAIT: begin
                    if (Start) begin
                        a_r   <= a;
                        b_r   <= b;
                        c_r   <= c;
                        Busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ab_r  <= a_r + b_r;
                    ac_r  <= a_r + c_r;
                    cnt   <= CNT_W'(MUL_LATENCY - 1);
                    state <= S_MUL;
                end
                S_MUL: begin
                    // MUL_LATENCY cycles: counter walks from MUL_LATENCY-1 to 0.
                    if (cnt == '0)
                        state <= S_COMMIT;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_COMMIT: begin
                    z     <= Z_WIDTH'(ab_gt ? ab_r : ac_r);
                    x     <= DATAWIDTH'(prod_r - PW'(ab_r));
                    Done  <= 1'b1;
                    state <= S_FINAL;
                end
                S_FINAL: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= S_WAIT;
                end
                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_test1_param.sv
// Directed bench for hls_test1_param. Three instances share clock, reset and
// operands: u0 defaults, u1 SIGNED=1, u2 MUL_LATENCY=4. Each has its own Start.
// Latency below is counted in edges after E0 up to the edge entering FINAL,
// i.e. MUL_LATENCY+2.
module tb_hls_test1_param;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] a, b, c;
    logic [2:0]  start_v;
    logic [2:0]  done_v, busy_v;
    logic [7:0]  z_v [3];
    logic [15:0] x_v [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    hls_test1_param #(.DATAWIDTH(16), .Z_WIDTH(8), .SIGNED(0), .MUL_LATENCY(2)) u0 (
        .Clk(Clk), .Rst(Rst), .Start(start_v[0]), .a(a), .b(b), .c(c),
        .Busy(busy_v[0]), .Done(done_v[0]), .z(z_v[0]), .x(x_v[0]));

    hls_test1_param #(.DATAWIDTH(16), .Z_WIDTH(8), .SIGNED(1), .MUL_LATENCY(2)) u1 (
        .Clk(Clk), .Rst(Rst), .Start(start_v[1]), .a(a), .b(b), .c(c),
        .Busy(busy_v[1]), .Done(done_v[1]), .z(z_v[1]), .x(x_v[1]));

    hls_test1_param #(.DATAWIDTH(16), .Z_WIDTH(8), .SIGNED(0), .MUL_LATENCY(4)) u2 (
        .Clk(Clk), .Rst(Rst), .Start(start_v[2]), .a(a), .b(b), .c(c),
        .Busy(busy_v[2]), .Done(done_v[2]), .z(z_v[2]), .x(x_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One full operation on instance d with a Start pulse.
    task automatic run_op(input int d, input logic [15:0] av, bv, cv,
                          input logic [7:0] ez, input logic [15:0] ex, input string tag);
        int  n;
        bit  busy_ok;
        a = av; b = bv; c = cv;
        start_v[d] = 1'b1;
        tick();                       // E0
        start_v[d] = 1'b0;
        busy_ok = 1'b1;
        n = 0;
        while (n < 30 && !done_v[d]) begin
            if (!busy_v[d]) busy_ok = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_lat"},  n, (d == 2) ? 6 : 4);
        chk({tag, "_busy"}, {31'd0, busy_ok & busy_v[d]}, 1);
        chk({tag, "_z"},    {24'd0, z_v[d]}, {24'd0, ez});
        chk({tag, "_x"},    {16'd0, x_v[d]}, {16'd0, ex});
        tick();
        chk({tag, "_done1cyc"}, {31'd0, done_v[d]}, 0);
        chk({tag, "_idle"},     {31'd0, busy_v[d]}, 0);
        chk({tag, "_zhold"},    {24'd0, z_v[d]}, {24'd0, ez});
    endtask

    initial begin
        int n, pulses, last, dones;
        Rst = 1'b1; start_v = '0; a = '0; b = '0; c = '0;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            chk("rst_done", {31'd0, done_v[d]}, 0);
            chk("rst_busy", {31'd0, busy_v[d]}, 0);
            chk("rst_z",    {24'd0, z_v[d]}, 0);
            chk("rst_x",    {16'd0, x_v[d]}, 0);
        end
        Rst = 1'b0;
        tick();

        // main function and boundaries
        run_op(0, 16'd10,   16'd20,   16'd30, 8'h28, 16'h010E, "def");
        run_op(0, 16'd1,    16'd5,    16'd5,  8'h06, 16'hFFFF, "tie");
        run_op(0, 16'h0100, 16'h0023, 16'h0,  8'h23, 16'hFEDD, "trunc");
        run_op(0, 16'hFFFF, 16'h0002, 16'h1,  8'h01, 16'hFFFE, "wrap");
        run_op(0, 16'h0000, 16'h8000, 16'h1,  8'h00, 16'h8000, "uns");
        run_op(1, 16'h0000, 16'h8000, 16'h1,  8'h01, 16'h8000, "sgn");
        run_op(1, 16'd10,   16'd20,   16'd30, 8'h28, 16'h010E, "sgn_def");

        // reset while in MUL abandons the op
        a = 16'd7; b = 16'd8; c = 16'd9;
        start_v[0] = 1'b1;
        tick();                       // E0 -> LOAD
        start_v[0] = 1'b0;
        tick();                       // -> MUL
        Rst = 1'b1;
        tick();
        chk("abort_z",    {24'd0, z_v[0]}, 0);
        chk("abort_x",    {16'd0, x_v[0]}, 0);
        chk("abort_busy", {31'd0, busy_v[0]}, 0);
        chk("abort_done", {31'd0, done_v[0]}, 0);
        tick();
        Rst = 1'b0;
        dones = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (done_v[0]) dones++;
        end
        chk("abort_nodone", dones, 0);
        run_op(0, 16'd10, 16'd20, 16'd30, 8'h28, 16'h010E, "post_rst");

        // Start held high on the MUL_LATENCY=4 instance
        a = 16'd10; b = 16'd20; c = 16'd30;
        start_v[2] = 1'b1;
        pulses = 0; last = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (done_v[2]) begin
                if (pulses > 0) chk("b2b_interval", e - last, 8);
                chk("b2b_z", {24'd0, z_v[2]}, 32'h28);
                last = e;
                pulses++;
            end
        end
        start_v[2] = 1'b0;
        chk("b2b_pulses", pulses, 5);
        repeat (3) tick();
        chk("b2b_idle", {31'd0, busy_v[2]}, 0);

        // operand changes and Start pulses while busy
        a = 16'd1; b = 16'd5; c = 16'd5;
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        n = 0;
        while (n < 30 && !done_v[2]) begin
            tick();
            n++;
            if (n == 1) begin a = 16'hFFFF; b = 16'd2; c = 16'd1; end
            if (n == 2 || n == 4) start_v[2] = 1'b1;
            if (n == 3 || n == 5) start_v[2] = 1'b0;
        end
        chk("robust_lat", n, 6);
        chk("robust_z", {24'd0, z_v[2]}, 32'h06);
        chk("robust_x", {16'd0, x_v[2]}, 32'hFFFF);
        repeat (4) tick();
        chk("robust_idle", {31'd0, busy_v[2]}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
